// File: rtl/knn_pkg.sv
// ---------------------------------------------------------------------------
// knn_pkg
// Shared definitions for the streaming top-K sorter:
//   knn_state_e  - query FSM states (IDLE / FILL / DRAIN)
//   knn_clamp_k  - maps a requested K onto the legal range 1..depth
// The slot entry (valid, value, id, optional label) depends on module
// parameters, so each module declares it with its own widths.
// Optional feature macro used by the sorter files: KNN_SORT_LABEL_EN.
// ---------------------------------------------------------------------------
package knn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } knn_state_e;

  // A request of 0 neighbours still returns the best one; oversize requests
  // are limited to the number of physical slots.
  function automatic int knn_clamp_k(input int k_raw, input int depth);
    if (k_raw <= 0) begin
      return 1;
    end
    if (k_raw > depth) begin
      return depth;
    end
    return k_raw;
  endfunction

endpackage

// File: rtl/knn_sort_cell.sv
// ---------------------------------------------------------------------------
// knn_sort_cell
// One slot of the insertion-sort chain. Holds a (valid, value, id[, label])
// entry, reports whether it yields to the incoming sample, and on an insert
// either shifts in its predecessor's entry or captures the new sample.
// Optional feature macro: KNN_SORT_LABEL_EN (adds label storage).
//
// Ports:
//   clk, reset        clock, synchronous active-low reset (valid bit only)
//   clr_i             clear the valid bit (query start)
//   ins_en_i          an accepted sample may update this slot
//   new_*_i           incoming sample fields
//   prev_yield_i      predecessor yields (tie 0 for slot 0)
//   prev_*_i          predecessor entry, shifted in when both slots yield
//   yield_o           slot is empty or holds a strictly larger distance
//   valid_o/value_o/id_o/label_o  current entry
// ---------------------------------------------------------------------------
module knn_sort_cell
  import knn_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ID_W    = 16,
  parameter int LABEL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              ins_en_i,
  input  logic [DATA_W-1:0] new_value_i,
  input  logic [ID_W-1:0]   new_id_i,
`ifdef KNN_SORT_LABEL_EN
  input  logic [LABEL_W-1:0] new_label_i,
  input  logic [LABEL_W-1:0] prev_label_i,
  output logic [LABEL_W-1:0] label_o,
`endif
  input  logic              prev_yield_i,
  input  logic              prev_valid_i,
  input  logic [DATA_W-1:0] prev_value_i,
  input  logic [ID_W-1:0]   prev_id_i,
  output logic              yield_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] value_o,
  output logic [ID_W-1:0]   id_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic [ID_W-1:0]   id_q, id_d;
`ifdef KNN_SORT_LABEL_EN
  logic [LABEL_W-1:0] label_q, label_d;
`else
  logic [LABEL_W-1:0] unused_label_w;
  assign unused_label_w = '0;
`endif

  // Strictly greater: an equal distance stays ahead of the newcomer, which
  // keeps ties in arrival order.
  assign yield_o = ~valid_q | (value_q > new_value_i);

  always_comb begin
    valid_d = valid_q;
    value_d = value_q;
    id_d    = id_q;
`ifdef KNN_SORT_LABEL_EN
    label_d = label_q;
`endif
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (ins_en_i && yield_o) begin
      if (prev_yield_i) begin
        // New sample lands further up the chain; make room by shifting.
        valid_d = prev_valid_i;
        value_d = prev_value_i;
        id_d    = prev_id_i;
`ifdef KNN_SORT_LABEL_EN
        label_d = prev_label_i;
`endif
      end else begin
        valid_d = 1'b1;
        value_d = new_value_i;
        id_d    = new_id_i;
`ifdef KNN_SORT_LABEL_EN
        label_d = new_label_i;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload is qualified by valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    value_q <= value_d;
    id_q    <= id_d;
`ifdef KNN_SORT_LABEL_EN
    label_q <= label_d;
`endif
  end

  assign valid_o = valid_q;
  assign value_o = value_q;
  assign id_o    = id_q;
`ifdef KNN_SORT_LABEL_EN
  assign label_o = label_q;
`endif

endmodule

// File: rtl/knn_topk_sorter.sv
// ---------------------------------------------------------------------------
// knn_topk_sorter
// Streaming top-K sorter: one distance per cycle is inserted into a chain of
// DEPTH sort cells that keeps the K smallest in ascending order (stable for
// ties), each tagged with its arrival index within the query. After the
// sample marked last, the kept entries are streamed out smallest first.
// Optional feature macro: KNN_SORT_LABEL_EN (label in/out and storage).
//
// Ports:
//   clk, reset              clock, synchronous active-low reset
//   start, k                open a query (IDLE only), requested K
//   in_valid/in_ready       sample handshake; in_value, in_last[, in_label]
//   out_valid/out_ready     result handshake; out_value, out_id,
//                           out_last[, out_label]
//   busy                    query in FILL or DRAIN
// ---------------------------------------------------------------------------
module knn_topk_sorter
  import knn_pkg::*;
#(
  parameter int   DATA_W  = 32,
  parameter int   ID_W    = 16,
  parameter int   DEPTH   = 64,
  parameter int   LABEL_W = 8,
  localparam int  K_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [K_W-1:0]    k,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_value,
  input  logic              in_last,
`ifdef KNN_SORT_LABEL_EN
  input  logic [LABEL_W-1:0] in_label,
  output logic [LABEL_W-1:0] out_label,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ID_W-1:0]   out_id,
  output logic [DATA_W-1:0] out_value,
  output logic              out_last,
  output logic              busy
);

  knn_state_e state_q, state_d;

  logic [K_W-1:0]    k_q, k_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [K_W-1:0]    count_q, count_d;
  logic [K_W-1:0]    rp_q, rp_d;

  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_value_q, out_value_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
`ifdef KNN_SORT_LABEL_EN
  logic [LABEL_W-1:0] out_label_q, out_label_d;
  logic [LABEL_W-1:0] slot_label [DEPTH];
  logic [LABEL_W-1:0] head_label, sel_label;
`else
  logic [LABEL_W-1:0] unused_label_w;
  assign unused_label_w = '0;
`endif

  logic [DEPTH-1:0]  slot_yield;
  logic [DEPTH-1:0]  slot_valid;
  logic [DATA_W-1:0] slot_value [DEPTH];
  logic [ID_W-1:0]   slot_id    [DEPTH];

  logic              accept;
  logic              clr;
  logic [K_W-1:0]    n_fill, n_drain, rp_nxt;
  logic [DATA_W-1:0] head_value, sel_value;
  logic [ID_W-1:0]   head_id, sel_id;

  assign in_ready = (state_q == ST_FILL);
  assign busy     = (state_q != ST_IDLE);
  assign accept   = in_valid & in_ready;
  assign clr      = (state_q == ST_IDLE) & start;

  // ---- FSM ----------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FILL;
      ST_FILL:  if (accept && in_last) state_d = ST_DRAIN;
      ST_DRAIN: if (out_valid_q && out_ready && out_last_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- query bookkeeping: K, sample ID, accepted count ---------------------
  always_comb begin
    k_d     = k_q;
    id_d    = id_q;
    count_d = count_q;
    if (clr) begin
      k_d     = K_W'(knn_clamp_k(int'(k), DEPTH));
      id_d    = '0;
      count_d = '0;
    end else if (accept) begin
      id_d = id_q + ID_W'(1);
      if (count_q != K_W'(DEPTH)) begin
        count_d = count_q + K_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      k_q     <= K_W'(1);
      id_q    <= '0;
      count_q <= '0;
    end else begin
      k_q     <= k_d;
      id_q    <= id_d;
      count_q <= count_d;
    end
  end

  // ---- sort chain -----------------------------------------------------------
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic              prev_yield, prev_valid;
    logic [DATA_W-1:0] prev_value;
    logic [ID_W-1:0]   prev_id;
`ifdef KNN_SORT_LABEL_EN
    logic [LABEL_W-1:0] prev_label;
`endif
    if (i == 0) begin : g_head
      // Nothing precedes slot 0, so it always captures the new sample.
      assign prev_yield = 1'b0;
      assign prev_valid = 1'b0;
      assign prev_value = '0;
      assign prev_id    = '0;
`ifdef KNN_SORT_LABEL_EN
      assign prev_label = '0;
`endif
    end else begin : g_link
      assign prev_yield = slot_yield[i-1];
      assign prev_valid = slot_valid[i-1];
      assign prev_value = slot_value[i-1];
      assign prev_id    = slot_id[i-1];
`ifdef KNN_SORT_LABEL_EN
      assign prev_label = slot_label[i-1];
`endif
    end

    knn_sort_cell #(
      .DATA_W  (DATA_W),
      .ID_W    (ID_W),
      .LABEL_W (LABEL_W)
    ) u_cell (
      .clk          (clk),
      .reset        (reset),
      .clr_i        (clr),
      // Slots at or beyond k_q are frozen; whatever would shift past
      // slot k_q-1 is simply dropped.
      .ins_en_i     (accept && (K_W'(i) < k_q)),
      .new_value_i  (in_value),
      .new_id_i     (id_q),
`ifdef KNN_SORT_LABEL_EN
      .new_label_i  (in_label),
      .prev_label_i (prev_label),
      .label_o      (slot_label[i]),
`endif
      .prev_yield_i (prev_yield),
      .prev_valid_i (prev_valid),
      .prev_value_i (prev_value),
      .prev_id_i    (prev_id),
      .yield_o      (slot_yield[i]),
      .valid_o      (slot_valid[i]),
      .value_o      (slot_value[i]),
      .id_o         (slot_id[i])
    );
  end

  // The tail slot has no successor to feed.
  logic unused_tail;
  assign unused_tail = slot_yield[DEPTH-1] ^ slot_valid[DEPTH-1];

  // ---- drain ----------------------------------------------------------------
  // Slot 0 after the final insert, computed ahead so the first result can be
  // registered in the same cycle the last sample is accepted.
  assign head_value = slot_yield[0] ? in_value : slot_value[0];
  assign head_id    = slot_yield[0] ? id_q     : slot_id[0];
`ifdef KNN_SORT_LABEL_EN
  assign head_label = slot_yield[0] ? in_label : slot_label[0];
`endif

  assign n_fill  = (count_d < k_q) ? count_d : k_q;
  assign n_drain = (count_q < k_q) ? count_q : k_q;
  assign rp_nxt  = rp_q + K_W'(1);

  always_comb begin
    sel_value = '0;
    sel_id    = '0;
`ifdef KNN_SORT_LABEL_EN
    sel_label = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (rp_nxt == K_W'(i)) begin
        sel_value = slot_value[i];
        sel_id    = slot_id[i];
`ifdef KNN_SORT_LABEL_EN
        sel_label = slot_label[i];
`endif
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_value_d = out_value_q;
    out_id_d    = out_id_q;
`ifdef KNN_SORT_LABEL_EN
    out_label_d = out_label_q;
`endif
    rp_d        = rp_q;
    case (state_q)
      ST_FILL: begin
        if (accept && in_last) begin
          out_valid_d = 1'b1;
          out_value_d = head_value;
          out_id_d    = head_id;
`ifdef KNN_SORT_LABEL_EN
          out_label_d = head_label;
`endif
          out_last_d  = (n_fill == K_W'(1));
          rp_d        = '0;
        end
      end
      ST_DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            rp_d        = rp_nxt;
            out_value_d = sel_value;
            out_id_d    = sel_id;
`ifdef KNN_SORT_LABEL_EN
            out_label_d = sel_label;
`endif
            out_last_d  = (rp_nxt == n_drain - K_W'(1));
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_value_q <= '0;
      out_id_q    <= '0;
`ifdef KNN_SORT_LABEL_EN
      out_label_q <= '0;
`endif
      rp_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_value_q <= out_value_d;
      out_id_q    <= out_id_d;
`ifdef KNN_SORT_LABEL_EN
      out_label_q <= out_label_d;
`endif
      rp_q        <= rp_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_value = out_value_q;
  assign out_id    = out_id_q;
`ifdef KNN_SORT_LABEL_EN
  assign out_label = out_label_q;
`endif

endmodule

// File: tb/tb_knn_topk_sorter.sv
// ---------------------------------------------------------------------------
// tb_knn_topk_sorter
// Directed bench for knn_topk_sorter (DEPTH=8). Expected drain entries come
// from a stable-sort reference model and are queued when samples are driven,
// then compared as the DUT presents results.
// ---------------------------------------------------------------------------
module tb_knn_topk_sorter;

  localparam int DATA_W  = 32;
  localparam int ID_W    = 16;
  localparam int DEPTH   = 8;
  localparam int LABEL_W = 8;
  localparam int K_W     = $clog2(DEPTH + 1);

  logic              clk;
  logic              reset;
  logic              start;
  logic [K_W-1:0]    k;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_value;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ID_W-1:0]   out_id;
  logic [DATA_W-1:0] out_value;
  logic              out_last;
  logic              busy;
`ifdef KNN_SORT_LABEL_EN
  logic [LABEL_W-1:0] in_label;
  logic [LABEL_W-1:0] out_label;
`endif

  knn_topk_sorter #(
    .DATA_W  (DATA_W),
    .ID_W    (ID_W),
    .DEPTH   (DEPTH),
    .LABEL_W (LABEL_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .k         (k),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_last   (in_last),
`ifdef KNN_SORT_LABEL_EN
    .in_label  (in_label),
    .out_label (out_label),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_value (out_value),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] v;
    logic [ID_W-1:0]   id;
    logic              last;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] stim_q[$];
  int                checks = 0;
  int                errors = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0,1 repeating
  task automatic drain(input int mode);
    int   cyc;
    bit   done;
    exp_t e;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 200) begin
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 64'(out_valid), 64'd0);
          done = 1'b1;
        end else begin
          e = sb[0];
          chk("out_value", 64'(out_value), 64'(e.v));
          chk("out_id",    64'(out_id),    64'(e.id));
          chk("out_last",  64'(out_last),  64'(e.last));
          if (out_ready) begin
            void'(sb.pop_front());
            if (e.last) done = 1'b1;
          end
        end
      end else begin
        chk("out_valid_in_drain", 64'(out_valid), 64'd1);
      end
      tick();
      cyc++;
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout: observed %0d cycles without out_last, required completion", cyc);
    end
    out_ready = 1'b0;
    chk("busy_after_drain",      64'(busy),      64'd0);
    chk("out_valid_after_drain", 64'(out_valid), 64'd0);
    chk("scoreboard_empty",      64'(sb.size()), 64'd0);
  endtask

  // Drives one query from stim_q and queues its expected drain sequence.
  task automatic run_query(input int kk, input int mode);
    logic [DATA_W-1:0] mv[$];
    logic [ID_W-1:0]   mi[$];
    int                pos, kc, n;
    bit                found;
    exp_t              e;
    start = 1'b1;
    k     = K_W'(kk);
    tick();
    start = 1'b0;
    chk("in_ready_after_start", 64'(in_ready), 64'd1);
    chk("busy_in_fill",         64'(busy),     64'd1);
    for (int s = 0; s < stim_q.size(); s++) begin
      in_valid = 1'b1;
      in_value = stim_q[s];
      in_last  = (s == stim_q.size() - 1);
      pos   = mv.size();
      found = 1'b0;
      for (int j = 0; j < mv.size(); j++) begin
        if (!found && mv[j] > stim_q[s]) begin
          pos   = j;
          found = 1'b1;
        end
      end
      mv.insert(pos, stim_q[s]);
      mi.insert(pos, ID_W'(s));
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    kc = (kk == 0) ? 1 : ((kk > DEPTH) ? DEPTH : kk);
    n  = (mv.size() < kc) ? mv.size() : kc;
    for (int j = 0; j < n; j++) begin
      e.v    = mv[j];
      e.id   = mi[j];
      e.last = (j == n - 1);
      sb.push_back(e);
    end
    chk("out_valid_after_last", 64'(out_valid), 64'd1);
    drain(mode);
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    k         = '0;
    in_valid  = 1'b0;
    in_value  = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
`ifdef KNN_SORT_LABEL_EN
    in_label  = '0;
`endif
    tick();
    tick();
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last",  64'(out_last),  64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_out_value", 64'(out_value), 64'd0);
    chk("rst_out_id",    64'(out_id),    64'd0);
    reset = 1'b1;
    tick();

    // Basic top-3 selection
    stim_q = '{32'd50, 32'd10, 32'd30, 32'd20, 32'd40};
    run_query(3, 0);

    // Ties keep arrival order; n limited by count
    stim_q = '{32'd7, 32'd7, 32'd7};
    run_query(4, 0);

    // k=0 clamps to 1, k above DEPTH clamps to DEPTH
    stim_q.delete();
    for (int i = 0; i < 10; i++) stim_q.push_back(DATA_W'(100 - i));
    run_query(0, 0);
    run_query(15, 0);

    // All-ones distance is an ordinary value
    stim_q = '{32'hFFFF_FFFF};
    run_query(2, 0);

    // Stalled drain, then back-to-back query
    stim_q = '{32'd9, 32'd3, 32'd12, 32'd3, 32'd1, 32'd8};
    run_query(5, 1);
    stim_q = '{32'd4, 32'd2};
    run_query(2, 1);

    // Reset in the middle of FILL
    start = 1'b1;
    k     = K_W'(3);
    tick();
    start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      in_valid = 1'b1;
      in_value = DATA_W'(s + 1);
      tick();
    end
    in_valid = 1'b0;
    reset    = 1'b0;
    tick();
    chk("midfill_rst_busy",      64'(busy),      64'd0);
    chk("midfill_rst_in_ready",  64'(in_ready),  64'd0);
    chk("midfill_rst_out_valid", 64'(out_valid), 64'd0);
    reset = 1'b1;
    tick();
    stim_q = '{32'd5};
    run_query(2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
